bus2_arbiter: RTL and testbench

- Clocked arbiter that shares the two-user dual-rail bus (bus2) between user0 and user1.
- Issues one-hot grants and a registered select to the bus mux.
- Enforces a one-cycle release gap between owners and round-robin fairness.
- Revokes ownership from a user that holds the bus past a watchdog limit.

---
 rtl/bus2_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus2_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus2_arbiter.sv
// rtl/bus2_arbiter.sv - two-user bus arbiter with release gap, round-robin ties and hold watchdog
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req0, req1   user requests, held high for a whole transaction
//   grant0/1     one-hot ownership grants (registered)
//   sel          bus mux select, 0 = user0, 1 = user1 (registered)
//   busy         high while either grant is high (registered)
//   timeout_err  one-cycle pulse when an owner is revoked by the watchdog
//   err_user     user revoked by the most recent watchdog event
//
// Parameters:
//   TIMEOUT      maximum grant length in cycles, 0 disables the watchdog
//   CW           hold counter width

module bus2_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1,
    output logic sel,
    output logic busy,
    output logic timeout_err,
    output logic err_user
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT0  = 2'd1,
        S_GRANT1  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam int            LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT   = CW'(LIMIT_I);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic          last;
    logic [CW-1:0] counter;
    logic          lock0;
    logic          lock1;

    logic          eff0;
    logic          eff1;
    logic          wd_hit;
    logic          pick0;

    // A locked-out user is invisible to arbitration until it drops its request.
    assign eff0   = req0 & ~lock0;
    assign eff1   = req1 & ~lock1;

    // Watchdog fires on the edge that would start cycle TIMEOUT+1 of ownership.
    assign wd_hit = WD_EN && (counter == LIMIT);

    // On a tie the user that did not own the bus last time wins.
    assign pick0  = eff0 & (~eff1 | last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            last        <= 1'b1;
            counter     <= '0;
            lock0       <= 1'b0;
            lock1       <= 1'b0;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            sel         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_user    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            // Any cycle with the request low re-arms a locked user. A lock is
            // only ever set while the request is high, so these never collide.
            if (!req0) begin
                lock0 <= 1'b0;
            end
            if (!req1) begin
                lock1 <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pick0) begin
                        state   <= S_GRANT0;
                        grant0  <= 1'b1;
                        sel     <= 1'b0;
                        last    <= 1'b0;
                        busy    <= 1'b1;
                        counter <= '0;
                    end else if (eff1) begin
                        state   <= S_GRANT1;
                        grant1  <= 1'b1;
                        sel     <= 1'b1;
                        last    <= 1'b1;
                        busy    <= 1'b1;
                        counter <= '0;
                    end
                end

                S_GRANT0: begin
                    if (!req0) begin
                        // A drop on the watchdog edge is a clean release.
                        state  <= S_RELEASE;
                        grant0 <= 1'b0;
                        busy   <= 1'b0;
                    end else if (wd_hit) begin
                        state       <= S_RELEASE;
                        grant0      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        err_user    <= 1'b0;
                        lock0       <= 1'b1;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + CW'(1);
                    end
                end

                S_GRANT1: begin
                    if (!req1) begin
                        state  <= S_RELEASE;
                        grant1 <= 1'b0;
                        busy   <= 1'b0;
                    end else if (wd_hit) begin
                        state       <= S_RELEASE;
                        grant1      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        err_user    <= 1'b1;
                        lock1       <= 1'b1;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + CW'(1);
                    end
                end

                // One dead cycle so the bus drivers of the old owner turn off
                // before the next owner is chosen; sel keeps its old value.
                S_RELEASE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    grant0 <= 1'b0;
                    grant1 <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus2_arbiter.sv
// tb/tb_bus2_arbiter.sv - self-checking bench for bus2_arbiter (TIMEOUT=4 and TIMEOUT=0 instances)

module tb_bus2_arbiter;

    logic clk;
    logic reset;
    logic req0;
    logic req1;

    logic g0_a, g1_a, sel_a, busy_a, te_a, eu_a;
    logic g0_b, g1_b, sel_b, busy_b, te_b, eu_b;

    int n_cmp = 0;
    int n_bad = 0;

    bus2_arbiter #(.TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .grant0(g0_a), .grant1(g1_a), .sel(sel_a), .busy(busy_a),
        .timeout_err(te_a), .err_user(eu_a)
    );

    bus2_arbiter #(.TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .grant0(g0_b), .grant1(g1_b), .sel(sel_b), .busy(busy_b),
        .timeout_err(te_b), .err_user(eu_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] out_a = {g0_a, g1_a, sel_a, busy_a, te_a, eu_a};
    wire [5:0] out_b = {g0_b, g1_b, sel_b, busy_b, te_b, eu_b};

    // Reference model: who owns the bus, how many cycles it has held it,
    // whether we are in the post-release gap, and per-user lockout.
    typedef struct packed {
        int     owner;
        int     held;
        bit     gap;
        int     last;
        bit [1:0] lock;
        bit     terr;
        bit     euser;
        bit     sel;
    } mstate_t;

    mstate_t m_a;
    mstate_t m_b;

    function automatic mstate_t mreset();
        mstate_t n;
        n.owner = -1; n.held = 0; n.gap = 1'b0; n.last = 1;
        n.lock = 2'b00; n.terr = 1'b0; n.euser = 1'b0; n.sel = 1'b0;
        return n;
    endfunction

    function automatic mstate_t mstep(mstate_t m, bit rs, bit [1:0] r, int t);
        mstate_t n;
        bit [1:0] want;
        int w;
        if (!rs) return mreset();
        n = m;
        n.terr = 1'b0;
        if (m.owner >= 0) begin
            if (!r[m.owner]) begin
                n.owner = -1;
                n.gap = 1'b1;
            end else if (t != 0 && m.held + 1 == t) begin
                n.owner = -1;
                n.gap = 1'b1;
                n.terr = 1'b1;
                n.euser = m.owner[0];
                n.lock[m.owner] = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else if (m.gap) begin
            n.gap = 1'b0;
        end else begin
            want = r & ~m.lock;
            if (want == 2'b11) w = 1 - m.last;
            else if (want[0]) w = 0;
            else if (want[1]) w = 1;
            else w = -1;
            if (w >= 0) begin
                n.owner = w;
                n.held = 0;
                n.last = w;
                n.sel = w[0];
            end
        end
        for (int i = 0; i < 2; i++) if (!r[i]) n.lock[i] = 1'b0;
        return n;
    endfunction

    function automatic logic [5:0] mexp(mstate_t m);
        return {m.owner == 0, m.owner == 1, m.sel, m.owner >= 0, m.terr, m.euser};
    endfunction

    task automatic check6(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%b expected=%b (g0 g1 sel busy terr euser)", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, advance both models, compare 1ns later.
    task automatic step(input bit rs, input bit r0, input bit r1);
        reset = rs;
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        m_a = mstep(m_a, rs, {r1, r0}, 4);
        m_b = mstep(m_b, rs, {r1, r0}, 0);
        #1;
        check6("model_t4", out_a, mexp(m_a));
        check6("model_t0", out_b, mexp(m_b));
    endtask

    typedef struct {
        bit       rs;
        bit       r0;
        bit       r1;
        logic [5:0] exp;
    } vec_t;

    vec_t tab[19];

    int  cnt;
    int  cnt2;
    int  found;
    bit  rr0;
    bit  rr1;
    bit  rrs;

    initial begin
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        m_a = mreset();
        m_b = mreset();

        // {reset, req0, req1} -> {g0 g1 sel busy terr euser} after the edge
        tab[0]  = '{1'b0, 1'b1, 1'b0, 6'b000000};
        tab[1]  = '{1'b1, 1'b1, 1'b0, 6'b100100};
        tab[2]  = '{1'b1, 1'b1, 1'b0, 6'b100100};
        tab[3]  = '{1'b1, 1'b0, 1'b0, 6'b000000};
        tab[4]  = '{1'b1, 1'b0, 1'b0, 6'b000000};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tab[6]  = '{1'b1, 1'b1, 1'b1, 6'b100100};
        tab[7]  = '{1'b1, 1'b0, 1'b1, 6'b000000};
        tab[8]  = '{1'b1, 1'b0, 1'b1, 6'b000000};
        tab[9]  = '{1'b1, 1'b0, 1'b1, 6'b011100};
        tab[10] = '{1'b1, 1'b1, 1'b1, 6'b011100};
        tab[11] = '{1'b1, 1'b1, 1'b0, 6'b001000};
        tab[12] = '{1'b1, 1'b1, 1'b1, 6'b001000};
        tab[13] = '{1'b1, 1'b1, 1'b1, 6'b100100};
        tab[14] = '{1'b1, 1'b0, 1'b1, 6'b000000};
        tab[15] = '{1'b1, 1'b1, 1'b1, 6'b000000};
        tab[16] = '{1'b1, 1'b1, 1'b1, 6'b011100};
        tab[17] = '{1'b1, 1'b0, 1'b0, 6'b001000};
        tab[18] = '{1'b1, 1'b0, 1'b0, 6'b001000};

        #2;
        for (int i = 0; i < 19; i++) begin
            step(tab[i].rs, tab[i].r0, tab[i].r1);
            check6($sformatf("tab%0d_t4", i), out_a, tab[i].exp);
            check6($sformatf("tab%0d_t0", i), out_b, tab[i].exp);
        end

        // Watchdog: user1 held, TIMEOUT=4 instance owns for exactly 4 cycles.
        step(1'b0, 1'b0, 1'b0);
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (g1_a) cnt++;
            if (te_a) begin
                cnt2++;
                check_int("to_err_user", int'(eu_a), 1);
            end
        end
        check_int("to_hold_cycles", cnt, 4);
        check_int("to_pulses", cnt2, 1);
        check_int("t0_still_granted", int'(g1_b), 1);

        // Locked user1 must not starve user0.
        step(1'b1, 1'b1, 1'b1);
        check_int("no_starve", int'(g0_a), 1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_int("locked_no_grant", int'(g1_a), 0);
        step(1'b1, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (g1_a) found = 1;
        end
        check_int("relock_regrant", found, 1);

        // Asynchronous reset between edges mid-transaction.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_int("pre_async_g0", int'(g0_a), 1);
        #2;
        reset = 1'b0;
        #1;
        check6("async_rst_t4", out_a, 6'b000000);
        check6("async_rst_t0", out_b, 6'b000000);
        m_a = mreset();
        m_b = mreset();
        step(1'b1, 1'b0, 1'b1);
        check_int("post_rst_g1", int'(g1_a), 1);

        // Watchdog disabled: 1000-cycle hold with no error and no drop.
        step(1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (!g0_b || te_b) cnt++;
        end
        check_int("t0_long_hold", cnt, 0);

        // Randomised traffic with occasional resets.
        rr0 = 1'b0;
        rr1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rr0 = ~rr0;
            if ($urandom_range(0, 5) == 0) rr1 = ~rr1;
            rrs = ($urandom_range(0, 199) != 0);
            step(rrs, rr0, rr1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
